dtree_seq_eval: RTL and testbench
=================================

Name: dtree_seq_eval

Overview:
- Sequential decision-tree classifier engine for the printed-classifier flow.
- Replaces a hard-wired combinational tree with one shared comparator and a register-file node table, loaded at run time through a config port.
- Walks one tree node per clock from root to leaf.
- Accepts a packed feature vector on a valid/ready input and returns a class on a valid/ready output.

Parameters:
- N_FEAT, 16, number of input features (feature index width FIDX_W = clog2(N_FEAT) = 4).
- FEAT_W, 8, bits per feature and per threshold.
- NODE_AW, 6, node address width; table depth 2^NODE_AW = 64.
- CLASS_W, 4, class code width.
- MAX_DEPTH, 8, maximum internal nodes traversed before abort.
- ERR_CLASS, 4'hF, class reported on abort.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  feature vector valid.
- in_ready  out  1  engine idle and able to accept.
- in_feat  in  N_FEAT*FEAT_W  packed features; feature i = in_feat[i*FEAT_W +: FEAT_W].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_class  out  CLASS_W  leaf class or ERR_CLASS.
- out_err  out  1  abort flag (depth exceeded or bad feature index).
- out_depth  out  4  internal nodes traversed for this result.
- cfg_we  in  1  node table write strobe.
- cfg_addr  in  NODE_AW  node index.
- cfg_data  in  NODE_W  node word, NODE_W = 1+FIDX_W+FEAT_W+2*NODE_AW = 25.
- cfg_busy  out  1  high when state != IDLE.
- eval_count  out  16  completed results, wraps at 65535 -> 0.

Behaviour:
- Node word (default widths):
  - [24] leaf.
  - [23:20] fidx.
  - [19:12] threshold.
  - [11:6] left child.
  - [5:0] right child.
  - For a leaf, class is in [3:0]; all other bits are ignored.
- Decision rule: feature[fidx] <= threshold (unsigned) -> left child, else right child. Root is node 0.
- Reset values:
  - State IDLE.
  - All table words 0.
  - Feature register 0.
  - out_valid=0, out_class=0, out_err=0, out_depth=0, eval_count=0.
  - in_ready=1, cfg_busy=0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, capture in_feat, set ptr=0 and depth=0, go to WALK.
  - WALK: examine table[ptr] combinationally; exactly one node per cycle.
    - Leaf: out_class<=class, out_err<=0, out_depth<=depth, out_valid<=1, go to DONE.
    - Internal with depth==MAX_DEPTH, or fidx>=N_FEAT: out_class<=ERR_CLASS, out_err<=1, out_depth<=depth, out_valid<=1, go to DONE.
    - Otherwise: ptr<=selected child, depth<=depth+1.
  - DONE: hold out_valid and all out_* stable until out_ready. On out_valid&out_ready: out_valid<=0, eval_count+1, go to IDLE. in_ready stays 0 in DONE.
- Latency: out_valid rises k+1 clock edges after the accept edge, where k is the number of internal nodes on the path. No combinational in->out path.
- Abort latency: MAX_DEPTH+1 edges.
- Config:
  - cfg_we is honoured only in IDLE; the write lands at the next edge.
  - Writes while cfg_busy=1 are dropped silently.
  - An in_valid accept and a cfg write in the same IDLE cycle are both performed; the walk uses the already-updated table, because the write lands at the accept edge, before the first WALK cycle.
- Child pointers are not range-checked (the table covers the full NODE_AW space). Cycles in the tree terminate via the depth guard.
- rst mid-walk or in DONE: immediate return to reset values, including clearing the table. The pending result is lost.
- out_ready asserted while out_valid=0 has no effect.

Test Plan:
- Tree build: load node0 = {0, fidx15, thr127, L1, R2}, node1 = leaf 3, node2 = {0, fidx15, thr191, L3, R4}, node3 = leaf 7, node4 = leaf 9.
  - feature15=100 -> out_class=3, out_depth=1, out_valid 2 edges after accept.
  - feature15=200 -> out_class=9, out_depth=2, 3 edges.
- Threshold boundaries on the same tree:
  - feature15=127 -> class 3.
  - feature15=128 -> class 7.
  - feature15=191 -> class 7.
  - feature15=192 -> class 9.
- Unloaded table after reset (all nodes internal, fidx0, thr0, children 0) -> out_err=1, out_class=4'hF, out_depth=8, out_valid 9 edges after accept.
- Back-pressure: hold out_ready=0 for 5 cycles -> out_valid, out_class and out_depth remain stable and in_ready=0. On release, eval_count increments by exactly 1 and in_ready=1 on the following cycle.
- Config gating: a cfg write to node1 with leaf class 5 issued mid-WALK is dropped, so a repeat run with feature15=100 still returns 3. The same write issued in IDLE makes the next run return 5.
- Assert rst during WALK -> next cycle out_valid=0, eval_count=0, in_ready=1, and the table is cleared (next eval aborts with ERR_CLASS).

Source files
------------

// File: rtl/dtree_seq_eval_if.sv
`default_nettype none
// ============================================================================
// Module   : dtree_seq_eval_if
// Purpose  : Feature-in / class-out handshakes and node-table config port
//            of the sequential decision-tree engine.
// Revision : 1.0 - initial release
// ============================================================================
interface dtree_seq_eval_if #(
    parameter int N_FEAT  = 16,
    parameter int FEAT_W  = 8,
    parameter int NODE_AW = 6,
    parameter int CLASS_W = 4
);
    localparam int c_fidx_w = $clog2(N_FEAT);
    localparam int c_node_w = 1 + c_fidx_w + FEAT_W + 2 * NODE_AW;

    logic                       in_valid;
    logic                       in_ready;
    logic [N_FEAT*FEAT_W-1:0]   in_feat;
    logic                       out_valid;
    logic                       out_ready;
    logic [CLASS_W-1:0]         out_class;
    logic                       out_err;
    logic [3:0]                 out_depth;
    logic                       cfg_we;
    logic [NODE_AW-1:0]         cfg_addr;
    logic [c_node_w-1:0]        cfg_data;
    logic                       cfg_busy;
    logic [15:0]                eval_count;

    modport master (
        output in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_data,
        input  in_ready, out_valid, out_class, out_err, out_depth, cfg_busy, eval_count
    );

    modport slave (
        input  in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_data,
        output in_ready, out_valid, out_class, out_err, out_depth, cfg_busy, eval_count
    );
endinterface
`default_nettype wire

// File: rtl/dtree_seq_eval.sv
`default_nettype none
// ============================================================================
// Module   : dtree_seq_eval
// Purpose  : Sequential decision-tree classifier walking one node per clock
//            through a run-time loadable node table with a single comparator.
// Revision : 1.0 - initial release
// ============================================================================
module dtree_seq_eval #(
    parameter int                 N_FEAT    = 16,
    parameter int                 FEAT_W    = 8,
    parameter int                 NODE_AW   = 6,
    parameter int                 CLASS_W   = 4,
    parameter int                 MAX_DEPTH = 8,
    parameter logic [CLASS_W-1:0] ERR_CLASS = 4'hF
) (
    input wire              clk,
    input wire              rst,
    dtree_seq_eval_if.slave bus
);
    localparam int c_fidx_w   = $clog2(N_FEAT);
    localparam int c_node_w   = 1 + c_fidx_w + FEAT_W + 2 * NODE_AW;
    localparam int c_nodes    = 1 << NODE_AW;
    localparam int c_leaf_bit = c_node_w - 1;
    localparam int c_fidx_lsb = FEAT_W + 2 * NODE_AW;
    localparam int c_thr_lsb  = 2 * NODE_AW;

    localparam logic [1:0] c_s_idle = 2'd0;
    localparam logic [1:0] c_s_walk = 2'd1;
    localparam logic [1:0] c_s_done = 2'd2;

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_nxt;

    logic [c_node_w-1:0]        r_table [c_nodes];
    logic [N_FEAT*FEAT_W-1:0]   r_feat;
    logic [NODE_AW-1:0]         r_ptr;
    logic [3:0]                 r_depth;

    logic                       r_out_valid;
    logic [CLASS_W-1:0]         r_out_class;
    logic                       r_out_err;
    logic [3:0]                 r_out_depth;
    logic [15:0]                r_eval_count;

    logic [c_node_w-1:0]        w_node;
    logic                       w_leaf;
    logic [c_fidx_w-1:0]        w_fidx;
    logic [FEAT_W-1:0]          w_thr;
    logic [NODE_AW-1:0]         w_left;
    logic [NODE_AW-1:0]         w_right;
    logic [CLASS_W-1:0]         w_class;
    logic [FEAT_W-1:0]          w_feat_arr [N_FEAT];
    logic [FEAT_W-1:0]          w_feat_sel;
    logic                       w_bad_fidx;
    logic                       w_depth_hit;
    logic                       w_abort;
    logic                       w_go_left;

    logic                       w_in_ready;
    logic                       w_cfg_busy;
    logic                       w_accept;
    logic                       w_cfg_wr;
    logic                       w_step;
    logic                       w_finish;
    logic                       w_release;

    // ---------------------------------------------------------------------
    // Node decode and the single shared comparator
    // ---------------------------------------------------------------------
    assign w_node  = r_table[r_ptr];
    assign w_leaf  = w_node[c_leaf_bit];
    assign w_fidx  = w_node[c_fidx_lsb +: c_fidx_w];
    assign w_thr   = w_node[c_thr_lsb +: FEAT_W];
    assign w_left  = w_node[NODE_AW +: NODE_AW];
    assign w_right = w_node[0 +: NODE_AW];
    assign w_class = w_node[0 +: CLASS_W];

    generate
        for (genvar gi = 0; gi < N_FEAT; gi++) begin : g_feat_unpack
            assign w_feat_arr[gi] = r_feat[gi*FEAT_W +: FEAT_W];
        end
    endgenerate

    // Index range guard only matters when N_FEAT is not a power of two.
    assign w_bad_fidx  = (32'(w_fidx) >= 32'(N_FEAT));
    assign w_feat_sel  = w_bad_fidx ? '0 : w_feat_arr[w_fidx];
    assign w_go_left   = (w_feat_sel <= w_thr);
    assign w_depth_hit = (r_depth == 4'(MAX_DEPTH));
    assign w_abort     = !w_leaf && (w_depth_hit || w_bad_fidx);

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_s_idle: begin
                if (bus.in_valid) begin
                    w_state_nxt = c_s_walk;
                end
            end
            c_s_walk: begin
                if (w_leaf || w_abort) begin
                    w_state_nxt = c_s_done;
                end
            end
            c_s_done: begin
                if (r_out_valid && bus.out_ready) begin
                    w_state_nxt = c_s_idle;
                end
            end
            default: w_state_nxt = c_s_idle;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: output / strobe decode
    // ---------------------------------------------------------------------
    always_comb begin
        w_in_ready = (r_state == c_s_idle);
        w_cfg_busy = (r_state != c_s_idle);
        w_accept   = w_in_ready && bus.in_valid;
        w_cfg_wr   = w_in_ready && bus.cfg_we;
        w_step     = (r_state == c_s_walk) && !w_leaf && !w_abort;
        w_finish   = (r_state == c_s_walk) && (w_leaf || w_abort);
        w_release  = (r_state == c_s_done) && r_out_valid && bus.out_ready;
    end

    // ---------------------------------------------------------------------
    // Node table; a write in the accept cycle lands before the first walk step
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_nodes; i++) begin
                r_table[i] <= '0;
            end
        end else if (w_cfg_wr) begin
            r_table[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    // ---------------------------------------------------------------------
    // Walk pointer, depth counter and feature capture
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_feat  <= '0;
            r_ptr   <= '0;
            r_depth <= '0;
        end else if (w_accept) begin
            r_feat  <= bus.in_feat;
            r_ptr   <= '0;
            r_depth <= '0;
        end else if (w_step) begin
            r_ptr   <= w_go_left ? w_left : w_right;
            r_depth <= r_depth + 4'd1;
        end
    end

    // ---------------------------------------------------------------------
    // Result registers; held stable through DONE until the downstream takes them
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_class  <= '0;
            r_out_err    <= 1'b0;
            r_out_depth  <= '0;
            r_eval_count <= '0;
        end else if (w_finish) begin
            r_out_valid  <= 1'b1;
            r_out_class  <= w_abort ? ERR_CLASS : w_class;
            r_out_err    <= w_abort;
            r_out_depth  <= r_depth;
        end else if (w_release) begin
            r_out_valid  <= 1'b0;
            r_eval_count <= r_eval_count + 16'd1;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.cfg_busy   = w_cfg_busy;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_class  = r_out_class;
    assign bus.out_err    = r_out_err;
    assign bus.out_depth  = r_out_depth;
    assign bus.eval_count = r_eval_count;

endmodule
`default_nettype wire

// File: tb/tb_dtree_seq_eval.sv
`default_nettype none
// ============================================================================
// Module   : tb_dtree_seq_eval
// Purpose  : Self-checking bench for dtree_seq_eval against a tree-walk model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dtree_seq_eval;
    localparam int N_FEAT    = 16;
    localparam int FEAT_W    = 8;
    localparam int NODE_AW   = 6;
    localparam int CLASS_W   = 4;
    localparam int MAX_DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dtree_seq_eval_if #(.N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .NODE_AW(NODE_AW), .CLASS_W(CLASS_W)) bus ();

    dtree_seq_eval #(
        .N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .NODE_AW(NODE_AW), .CLASS_W(CLASS_W),
        .MAX_DEPTH(MAX_DEPTH), .ERR_CLASS(4'hF)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    logic [24:0] m_table [64];
    bit          m_live  = 1'b0;
    int          m_phase = 0;     // 0 idle, 1 evaluating, 2 result pending
    int          m_wait  = 0;
    logic [15:0] m_count = '0;
    logic [3:0]  m_cls   = '0;
    bit          m_err   = 1'b0;
    int          m_dep   = 0;

    // Walk the tree straight from the node-word definition.
    function automatic void model_eval(input logic [127:0] f, output logic [3:0] cls,
                                       output bit err, output int dep);
        int p = 0;
        cls = 4'hF; err = 1'b1; dep = 0;
        for (int guard = 0; guard <= MAX_DEPTH; guard++) begin
            logic [24:0] nd;
            int fx;
            nd = m_table[p];
            fx = int'(nd[23:20]);
            if (nd[24]) begin
                cls = nd[3:0]; err = 1'b0;
                return;
            end
            if (dep == MAX_DEPTH || fx >= N_FEAT) begin
                cls = 4'hF; err = 1'b1;
                return;
            end
            p = (f[fx*8 +: 8] <= nd[19:12]) ? int'(nd[11:6]) : int'(nd[5:0]);
            dep++;
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1'b1; m_phase = 0; m_wait = 0; m_count = '0;
            foreach (m_table[i]) m_table[i] = '0;
        end else begin
            case (m_phase)
                0: begin
                    if (bus.cfg_we) m_table[bus.cfg_addr] = bus.cfg_data;
                    if (bus.in_valid) begin
                        model_eval(bus.in_feat, m_cls, m_err, m_dep);
                        m_wait = m_dep + 1;
                        m_phase = 1;
                    end
                end
                1: begin
                    m_wait--;
                    if (m_wait == 0) m_phase = 2;
                end
                default: begin
                    if (bus.out_ready) begin
                        m_phase = 0;
                        m_count = m_count + 16'd1;
                    end
                end
            endcase
        end
    end

    // Single compare process, every cycle once reset has been seen.
    always @(negedge clk) begin
        if (m_live) begin
            check("in_ready",   32'(bus.in_ready),   32'(m_phase == 0));
            check("cfg_busy",   32'(bus.cfg_busy),   32'(m_phase != 0));
            check("out_valid",  32'(bus.out_valid),  32'(m_phase == 2));
            check("eval_count", 32'(bus.eval_count), 32'(m_count));
            if (m_phase == 2) begin
                check("out_class", 32'(bus.out_class), 32'(m_cls));
                check("out_err",   32'(bus.out_err),   32'(m_err));
                check("out_depth", 32'(bus.out_depth), 32'(m_dep));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [127:0] mk(input int f15);
        logic [127:0] v;
        for (int i = 0; i < 4; i++) v[i*32 +: 32] = $urandom;
        v[127:120] = 8'(f15);
        return v;
    endfunction

    function automatic logic [24:0] inode(input int fx, input int thr, input int l, input int r);
        return {1'b0, 4'(fx), 8'(thr), 6'(l), 6'(r)};
    endfunction

    function automatic logic [24:0] leaf(input int c);
        return {1'b1, 20'd0, 4'(c)};
    endfunction

    task automatic cfg_write(input logic [5:0] a, input logic [24:0] d);
        @(negedge clk);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
    endtask

    // Returns with the number of edges already elapsed since the accept edge.
    task automatic start(input logic [127:0] f, input bit cfg_same, input bit cfg_mid,
                         input logic [5:0] ca, input logic [24:0] cd, output int edges);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 64) begin @(negedge clk); n++; end
        check("idle_wait", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1; bus.in_feat = f;
        if (cfg_same) begin bus.cfg_we = 1'b1; bus.cfg_addr = ca; bus.cfg_data = cd; end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.cfg_we = 1'b0;
        edges = 0;
        if (cfg_mid) begin
            bus.cfg_we = 1'b1; bus.cfg_addr = ca; bus.cfg_data = cd;
            @(posedge clk); #1;
            bus.cfg_we = 1'b0;
            edges = 1;
        end
    endtask

    task automatic wait_result(input int edges0, output int lat);
        lat = edges0;
        while (!bus.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check("result_timeout", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic release_result(input int hold);
        repeat (hold) @(negedge clk);
        @(negedge clk); bus.out_ready = 1'b1;
        @(posedge clk); #1; bus.out_ready = 1'b0;
    endtask

    task automatic run(input string name, input int f15, input int ecls, input int eerr,
                       input int edep, input int elat);
        int e, lat;
        start(mk(f15), 1'b0, 1'b0, 6'd0, 25'd0, e);
        wait_result(e, lat);
        check({name, "_lat"},   32'(lat),           32'(elat));
        check({name, "_class"}, 32'(bus.out_class), 32'(ecls));
        check({name, "_err"},   32'(bus.out_err),   32'(eerr));
        check({name, "_depth"}, 32'(bus.out_depth), 32'(edep));
        release_result(0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, lat;
        logic [15:0] cnt0;
        bus.in_valid = 1'b0; bus.in_feat = '0; bus.out_ready = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        check("rst_out_valid",  32'(bus.out_valid),  32'd0);
        check("rst_out_class",  32'(bus.out_class),  32'd0);
        check("rst_out_err",    32'(bus.out_err),    32'd0);
        check("rst_out_depth",  32'(bus.out_depth),  32'd0);
        check("rst_eval_count", 32'(bus.eval_count), 32'd0);
        check("rst_in_ready",   32'(bus.in_ready),   32'd1);
        check("rst_cfg_busy",   32'(bus.cfg_busy),   32'd0);

        // Empty table: every node is internal with children 0 -> depth guard
        run("unloaded", 55, 15, 1, 8, 9);

        // Small tree on feature 15
        cfg_write(6'd0, inode(15, 127, 1, 2));
        cfg_write(6'd1, leaf(3));
        cfg_write(6'd2, inode(15, 191, 3, 4));
        cfg_write(6'd3, leaf(7));
        cfg_write(6'd4, leaf(9));
        run("f100", 100, 3, 0, 1, 2);
        run("f200", 200, 9, 0, 2, 3);
        run("f127", 127, 3, 0, 1, 2);
        run("f128", 128, 7, 0, 2, 3);
        run("f191", 191, 7, 0, 2, 3);
        run("f192", 192, 9, 0, 2, 3);

        // Back-pressure
        start(mk(100), 1'b0, 1'b0, 6'd0, 25'd0, e);
        wait_result(e, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid",    32'(bus.out_valid), 32'd1);
            check("bp_class",    32'(bus.out_class), 32'd3);
            check("bp_depth",    32'(bus.out_depth), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready),  32'd0);
        end
        cnt0 = m_count;
        release_result(0);
        check("bp_count",     32'(bus.eval_count), 32'(cnt0 + 16'd1));
        check("bp_ready_aft", 32'(bus.in_ready),   32'd1);

        // Config gating: write during the walk is dropped, write in IDLE lands
        start(mk(100), 1'b0, 1'b1, 6'd1, leaf(5), e);
        wait_result(e, lat);
        check("gate_mid_class", 32'(bus.out_class), 32'd3);
        release_result(0);
        run("gate_repeat", 100, 3, 0, 1, 2);
        cfg_write(6'd1, leaf(5));
        run("gate_idle", 100, 5, 0, 1, 2);

        // Reset during the walk wipes the table
        start(mk(200), 1'b0, 1'b0, 6'd0, 25'd0, e);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        check("mid_rst_valid",    32'(bus.out_valid),  32'd0);
        check("mid_rst_count",    32'(bus.eval_count), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready),   32'd1);
        run("post_rst", 200, 15, 1, 8, 9);

        // Randomised trees and traffic against the model
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 2) == 0)
                cfg_write(6'(i), {1'b1, 20'($urandom), 4'($urandom)});
            else
                cfg_write(6'(i), inode($urandom_range(0, 15), $urandom_range(0, 255),
                                       $urandom_range(0, 63), $urandom_range(0, 63)));
        end
        for (int k = 0; k < 60; k++) begin
            int mode;
            logic [24:0] wd;
            mode = $urandom_range(0, 3);
            wd = ($urandom_range(0, 1) == 0) ? {1'b1, 20'($urandom), 4'($urandom)}
                                             : {1'b0, 24'($urandom)};
            bus.out_ready = 1'($urandom_range(0, 1));
            start({$urandom, $urandom, $urandom, $urandom}, mode == 1, mode == 2,
                  6'($urandom_range(0, 63)), wd, e);
            wait_result(e, lat);
            release_result($urandom_range(0, 3));
        end
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
